branch_verify_unit: RTL and testbench
=====================================

BRANCH_VERIFY_UNIT -- requirements
Module: branch_verify_unit

Interface
REQ-001 Parameter NUM_WAYS, default 2, sets the number of retire ways inspected per cycle (1..4).
REQ-002 Parameter UPD_DEPTH, default 4, sets the update-FIFO depth (power of two, >=2).
REQ-003 Parameter FETCH_BYTES, default 8, sets the fetch-group alignment in bytes (power of two, >=4).
REQ-004 Parameter CNT_W, default 32, sets the performance-counter width.
REQ-005 Parameter TRAIN_ALL, default 0; when 1, non-branch records also carry PC_Vaild=1.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 resetn  in  1  reset, asynchronous and active-low.
REQ-008 stall  in  1  pipeline freeze; no capture, check or push occurs while high.
REQ-009 way_info  in  NUM_WAYS x bru_info  per-way retire info: valid, pc, true_pc, true_branch, branch_type, update_true_pc, bp_info.
REQ-010 bp_fail  out  1  combinational misprediction flush request.
REQ-011 upd_valid  out  1  FIFO head holds a predictor update.
REQ-012 upd_ready  in  1  predictor accepts the head record.
REQ-013 upd_data  out  Update_Branch_S  FIFO head record.
REQ-014 cnt_clear  in  1  synchronous clear of all counters.
REQ-015 cnt_total, cnt_miss, cnt_drop  out  CNT_W each  branch records pushed, mispredicted branch records pushed, and records dropped.

Function
REQ-016 The FSM SHALL have two states: IDLE (nothing saved) and CHECK (one record saved, expected next PC = saved true_pc).
REQ-017 A group is active when stall=0 and any way_info[i].valid=1; the first way is the lowest valid index.
REQ-018 bp_fail SHALL be 1 iff state=CHECK, the group is active, and the first way's pc != saved true_pc.
REQ-019 In CHECK, an active group SHALL push one update built from the saved record in the same cycle.
REQ-020 On bp_fail the next state SHALL be IDLE and the group SHALL NOT be captured (wrong path).
REQ-021 Otherwise an active group SHALL be captured and the next state SHALL be CHECK.
REQ-022 Capture selection: the lowest valid way with branch_type != None, else the highest valid way.
REQ-023 Captured fields: pc, true_pc, true_branch, branch_type, bp_info, update_true_pc, and is_branch = (branch_type != None).
REQ-024 Update_PC SHALL be pc with the low log2(FETCH_BYTES) bits cleared.
REQ-025 Update_Location SHALL be pc[log2(FETCH_BYTES)-1:2].
REQ-026 PC_Vaild SHALL be is_branch | TRAIN_ALL.
REQ-027 With update_true_pc=1: PC_Taken = true_branch, PC_MissPredict = bp_fail, Update_Target = true_pc.
REQ-028 With update_true_pc=0: PC_Taken = 0, PC_MissPredict = 1, Update_Target = pc+4 (mod 2^32).
REQ-029 The remaining record fields SHALL be copied from the saved bp_info and branch_type: counters, GHR, Recover_GHR, CPHT, Predict_Target, Predict_Location, Predict_BranchType.
REQ-030 The FIFO SHALL be first-in first-out; a pop occurs when upd_valid & upd_ready, independent of stall.
REQ-031 When the FIFO is full and no pop occurs, a push SHALL be dropped and cnt_drop incremented.
REQ-032 When the FIFO is full, a simultaneous push and pop SHALL both succeed.
REQ-033 A push into an empty FIFO SHALL appear on upd_valid in the next cycle.
REQ-034 Each pushed record with is_branch=1 SHALL increment cnt_total; if it also has PC_MissPredict=1 it SHALL increment cnt_miss.
REQ-035 All counters SHALL saturate at all-ones.
REQ-036 cnt_clear SHALL zero all counters and SHALL take priority over same-cycle increments.
REQ-037 With stall=1: state, saved record and counters SHALL hold, and bp_fail SHALL be 0.

Reset
REQ-038 resetn=0 SHALL immediately force: state IDLE, saved record zero with branch_type None, FIFO empty, counters zero, and upd_valid=0.
REQ-039 A reset arriving mid-operation SHALL discard pending FIFO records without issuing a pop.

Structure
REQ-040 bru_info, Update_Branch_S, Predict_Branch_S, BranchType_E and the FSM state enum SHALL reside in the shared CPU package.
REQ-041 The FIFO SHALL be a sub-module named bvu_update_fifo, parameterised by depth and record type.

Verification
REQ-042 Branch at 0x1000 saved (true_pc 0x2000), then next group way0.pc=0x2000 -> bp_fail=0; one push with PC_MissPredict=0, Update_PC=0x1000, Update_Location=0; cnt_total=1.
REQ-043 Same setup, then next group way0.pc=0x1008 -> bp_fail=1 in that cycle; state IDLE; push with PC_MissPredict=1; cnt_miss=1; the group is not captured.
REQ-044 NUM_WAYS=4, ways 0..3 valid with a branch in way2 only -> the way2 record is captured.
REQ-045 upd_ready=0 with 5 checked groups at UPD_DEPTH=4 -> 4 records queued and cnt_drop=1; then upd_ready=1 -> records pop in order.
REQ-046 stall=1 for 3 cycles with a valid mismatching group -> bp_fail=0 and no push.
REQ-047 resetn low mid-stream for 1 cycle -> upd_valid=0 at once and all counters 0.
REQ-048 Saved update_true_pc=0 with pc=0x3004 -> Update_Target=0x3008, PC_Taken=0.

Source files
------------

// File: rtl/branch_verify_unit_pkg.sv
// Shared CPU types for branch verification: retire info, predictor update record and FSM state.
package branch_verify_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned GHR_W = 8;
  localparam int unsigned LOC_W = 4;

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrCond = 3'd1,
    BrJump = 3'd2,
    BrCall = 3'd3,
    BrRet  = 3'd4
  } BranchType_E;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StCheck = 1'b1
  } bvu_state_e;

  typedef struct packed {
    logic [1:0]       Counter;
    logic [GHR_W-1:0] GHR;
    logic [GHR_W-1:0] Recover_GHR;
    logic [1:0]       CPHT;
    logic [XLEN-1:0]  Predict_Target;
    logic [LOC_W-1:0] Predict_Location;
    BranchType_E      Predict_BranchType;
  } Predict_Branch_S;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] true_pc;
    logic            true_branch;
    BranchType_E     branch_type;
    logic            update_true_pc;
    Predict_Branch_S bp_info;
  } bru_info;

  typedef struct packed {
    logic             PC_Vaild;
    logic             PC_Taken;
    logic             PC_MissPredict;
    logic [XLEN-1:0]  Update_PC;
    logic [LOC_W-1:0] Update_Location;
    logic [XLEN-1:0]  Update_Target;
    BranchType_E      Update_BranchType;
    logic [1:0]       Counter;
    logic [GHR_W-1:0] GHR;
    logic [GHR_W-1:0] Recover_GHR;
    logic [1:0]       CPHT;
    logic [XLEN-1:0]  Predict_Target;
    logic [LOC_W-1:0] Predict_Location;
    BranchType_E      Predict_BranchType;
  } Update_Branch_S;

  // Retire record held in CHECK while waiting for the next group's PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] true_pc;
    logic            true_branch;
    BranchType_E     branch_type;
    logic            update_true_pc;
    logic            is_branch;
    Predict_Branch_S bp_info;
  } bvu_saved_t;

  function automatic Update_Branch_S bvu_build_update(input bvu_saved_t      s,
                                                     input logic            miss,
                                                     input logic [XLEN-1:0] off_mask,
                                                     input logic            train_all);
    Update_Branch_S u;
    u                 = '0;
    u.PC_Vaild        = s.is_branch | train_all;
    u.Update_PC       = s.pc & ~off_mask;
    u.Update_Location = LOC_W'((s.pc & off_mask) >> 2);
    if (s.update_true_pc) begin
      u.PC_Taken       = s.true_branch;
      u.PC_MissPredict = miss;
      u.Update_Target  = s.true_pc;
    end else begin
      // No resolved target: train as a not-taken fall-through and force a correction.
      u.PC_Taken       = 1'b0;
      u.PC_MissPredict = 1'b1;
      u.Update_Target  = s.pc + XLEN'(4);
    end
    u.Update_BranchType  = s.branch_type;
    u.Counter            = s.bp_info.Counter;
    u.GHR                = s.bp_info.GHR;
    u.Recover_GHR        = s.bp_info.Recover_GHR;
    u.CPHT               = s.bp_info.CPHT;
    u.Predict_Target     = s.bp_info.Predict_Target;
    u.Predict_Location   = s.bp_info.Predict_Location;
    u.Predict_BranchType = s.bp_info.Predict_BranchType;
    return u;
  endfunction

endpackage

// File: rtl/bvu_update_fifo.sv
// Predictor-update queue: power-of-two depth, full-with-pop accepts a push, reset drops contents.
module bvu_update_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         rec_t = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  rec_t data_i,
  input  logic pop_i,
  output logic valid_o,
  output logic full_o,
  output logic accept_o,
  output rec_t data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW:0]   count_q, count_d;
  rec_t            mem_q [Depth];
  logic            do_push, do_pop;

  always_comb begin
    valid_o  = (count_q != '0);
    full_o   = (count_q == (PtrW + 1)'(Depth));
    do_pop   = pop_i & valid_o;
    do_push  = push_i & (~full_o | do_pop);
    accept_o = do_push;
    data_o   = mem_q[rptr_q];

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/branch_verify_unit.sv
// Checks each retired group's PC against the saved record's true target, raises a flush on
// mismatch, and queues predictor updates with performance counters.
module branch_verify_unit
  import branch_verify_unit_pkg::*;
#(
  parameter int unsigned NUM_WAYS    = 2,
  parameter int unsigned UPD_DEPTH   = 4,
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned CNT_W       = 32,
  parameter bit          TRAIN_ALL   = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  bru_info          way_info [NUM_WAYS],
  output logic             bp_fail,
  output logic             upd_valid,
  input  logic             upd_ready,
  output Update_Branch_S   upd_data,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_miss,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam int unsigned     IdxW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [XLEN-1:0] OffMask = XLEN'(FETCH_BYTES - 1);

  bvu_state_e      state_q, state_d;
  bvu_saved_t      saved_q, saved_d;
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_miss_q, cnt_miss_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  logic            any_valid, found_br, active, check;
  logic [IdxW-1:0] hi_idx, br_idx, cap_idx;
  logic [XLEN-1:0] first_pc;
  bvu_saved_t      captured;
  Update_Branch_S  upd_rec;
  logic            fifo_full, fifo_accept, upd_pop, push;
  logic            total_inc, miss_inc, drop_inc;

  // Group decode; the descending scan lets the lowest matching way win.
  always_comb begin
    any_valid = 1'b0;
    found_br  = 1'b0;
    hi_idx    = '0;
    br_idx    = '0;
    first_pc  = '0;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (way_info[i].valid) begin
        if (!any_valid) hi_idx = IdxW'(i);
        any_valid = 1'b1;
        first_pc  = way_info[i].pc;
        if (way_info[i].branch_type != BrNone) begin
          found_br = 1'b1;
          br_idx   = IdxW'(i);
        end
      end
    end
    cap_idx = found_br ? br_idx : hi_idx;
  end

  always_comb begin
    captured                = '0;
    captured.pc             = way_info[cap_idx].pc;
    captured.true_pc        = way_info[cap_idx].true_pc;
    captured.true_branch    = way_info[cap_idx].true_branch;
    captured.branch_type    = way_info[cap_idx].branch_type;
    captured.update_true_pc = way_info[cap_idx].update_true_pc;
    captured.is_branch      = (way_info[cap_idx].branch_type != BrNone);
    captured.bp_info        = way_info[cap_idx].bp_info;
  end

  always_comb begin
    active  = ~stall & any_valid;
    check   = (state_q == StCheck) & active;
    bp_fail = check & (first_pc != saved_q.true_pc);
    push    = check;
    upd_rec = bvu_build_update(saved_q, bp_fail, OffMask, TRAIN_ALL);

    state_d = state_q;
    saved_d = saved_q;
    if (bp_fail) begin
      // Group is on the wrong path: drop it and wait for the redirected stream.
      state_d = StIdle;
    end else if (active) begin
      state_d = StCheck;
      saved_d = captured;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  assign upd_pop = upd_valid & upd_ready;

  bvu_update_fifo #(
    .Depth (UPD_DEPTH),
    .rec_t (Update_Branch_S)
  ) u_update_fifo (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .push_i   (push),
    .data_i   (upd_rec),
    .pop_i    (upd_pop),
    .valid_o  (upd_valid),
    .full_o   (fifo_full),
    .accept_o (fifo_accept),
    .data_o   (upd_data)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    total_inc   = fifo_accept & saved_q.is_branch;
    miss_inc    = total_inc & upd_rec.PC_MissPredict;
    drop_inc    = push & ~fifo_accept;
    cnt_total_d = cnt_clear ? '0 : sat_inc(cnt_total_q, total_inc);
    cnt_miss_d  = cnt_clear ? '0 : sat_inc(cnt_miss_q, miss_inc);
    cnt_drop_d  = cnt_clear ? '0 : sat_inc(cnt_drop_q, drop_inc);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_total_q <= '0;
      cnt_miss_q  <= '0;
      cnt_drop_q  <= '0;
    end else begin
      cnt_total_q <= cnt_total_d;
      cnt_miss_q  <= cnt_miss_d;
      cnt_drop_q  <= cnt_drop_d;
    end
  end

  assign cnt_total = cnt_total_q;
  assign cnt_miss  = cnt_miss_q;
  assign cnt_drop  = cnt_drop_q;

endmodule

// File: tb/tb_branch_verify_unit.sv
// Directed bench for branch_verify_unit: vector table for check/update pairs plus corner sequences.
module tb_branch_verify_unit;
  import branch_verify_unit_pkg::*;

  localparam int unsigned NW = 4;

  logic           clk = 1'b0;
  logic           resetn, stall, upd_ready, cnt_clear;
  logic           bp_fail, upd_valid;
  bru_info        way_info [NW];
  Update_Branch_S upd_data;
  logic [31:0]    cnt_total, cnt_miss, cnt_drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_verify_unit #(
    .NUM_WAYS    (NW),
    .UPD_DEPTH   (4),
    .FETCH_BYTES (8),
    .CNT_W       (32),
    .TRAIN_ALL   (1'b0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .stall     (stall),
    .way_info  (way_info),
    .bp_fail   (bp_fail),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_data  (upd_data),
    .cnt_clear (cnt_clear),
    .cnt_total (cnt_total),
    .cnt_miss  (cnt_miss),
    .cnt_drop  (cnt_drop)
  );

  typedef struct {
    logic [31:0] a_pc;
    logic [31:0] a_tpc;
    BranchType_E a_bt;
    logic        a_tb;
    logic        a_utp;
    logic [31:0] b_pc;
    logic        e_fail;
    logic        e_vaild;
    logic        e_taken;
    logic        e_miss;
    logic [31:0] e_upc;
    logic [31:0] e_loc;
    logic [31:0] e_tgt;
    logic [31:0] e_tot;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_ways();
    for (int i = 0; i < int'(NW); i++) way_info[i] = '0;
  endtask

  task automatic set_way(input int i, input logic [31:0] pc, input logic [31:0] tpc,
                         input BranchType_E bt, input logic tb, input logic utp);
    way_info[i]                = '0;
    way_info[i].valid          = 1'b1;
    way_info[i].pc             = pc;
    way_info[i].true_pc        = tpc;
    way_info[i].branch_type    = bt;
    way_info[i].true_branch    = tb;
    way_info[i].update_true_pc = utp;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    stall     = 1'b0;
    upd_ready = 1'b0;
    cnt_clear = 1'b0;
    clear_ways();
    next_cycle();
    resetn = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'h1000, 32'h2000, BrCond, 1'b1, 1'b1, 32'h2000,
                1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'd0, 32'h2000, 32'd1, 32'd0};
    vecs[1] = '{32'h1000, 32'h2000, BrCond, 1'b1, 1'b1, 32'h1008,
                1'b1, 1'b1, 1'b1, 1'b1, 32'h1000, 32'd0, 32'h2000, 32'd1, 32'd1};
    vecs[2] = '{32'h3004, 32'h3100, BrCond, 1'b1, 1'b0, 32'h3100,
                1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 32'd1, 32'h3008, 32'd1, 32'd1};
    vecs[3] = '{32'h4014, 32'h4018, BrNone, 1'b0, 1'b1, 32'h4018,
                1'b0, 1'b0, 1'b0, 1'b0, 32'h4010, 32'd1, 32'h4018, 32'd0, 32'd0};
    vecs[4] = '{32'h500C, 32'h6000, BrJump, 1'b1, 1'b1, 32'h6004,
                1'b1, 1'b1, 1'b1, 1'b1, 32'h5008, 32'd1, 32'h6000, 32'd1, 32'd1};

    // Reset state while reset is held.
    resetn    = 1'b0;
    stall     = 1'b0;
    upd_ready = 1'b0;
    cnt_clear = 1'b0;
    clear_ways();
    #3;
    check("rst_upd_valid", 32'(upd_valid), 32'd0);
    check("rst_bp_fail", 32'(bp_fail), 32'd0);
    check("rst_cnt_total", cnt_total, 32'd0);
    check("rst_cnt_miss", cnt_miss, 32'd0);
    check("rst_cnt_drop", cnt_drop, 32'd0);

    // Table: capture A, check with B, probe state with a third group, inspect queued head.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clear_ways();
      set_way(0, vecs[v].a_pc, vecs[v].a_tpc, vecs[v].a_bt, vecs[v].a_tb, vecs[v].a_utp);
      next_cycle();
      clear_ways();
      set_way(0, vecs[v].b_pc, vecs[v].b_pc + 32'd4, BrNone, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_bp_fail", v), 32'(bp_fail), 32'(vecs[v].e_fail));
      next_cycle();
      clear_ways();
      set_way(0, 32'hDEAD0, 32'hDEAD4, BrNone, 1'b0, 1'b1);
      @(negedge clk);
      // After a flush the unit is idle (no check); otherwise it checks against b_pc+4.
      check($sformatf("v%0d_state_probe", v), 32'(bp_fail), 32'(!vecs[v].e_fail));
      next_cycle();
      clear_ways();
      @(negedge clk);
      check($sformatf("v%0d_upd_valid", v), 32'(upd_valid), 32'd1);
      check($sformatf("v%0d_pc_vaild", v), 32'(upd_data.PC_Vaild), 32'(vecs[v].e_vaild));
      check($sformatf("v%0d_taken", v), 32'(upd_data.PC_Taken), 32'(vecs[v].e_taken));
      check($sformatf("v%0d_miss", v), 32'(upd_data.PC_MissPredict), 32'(vecs[v].e_miss));
      check($sformatf("v%0d_upd_pc", v), upd_data.Update_PC, vecs[v].e_upc);
      check($sformatf("v%0d_upd_loc", v), 32'(upd_data.Update_Location), vecs[v].e_loc);
      check($sformatf("v%0d_upd_tgt", v), upd_data.Update_Target, vecs[v].e_tgt);
      check($sformatf("v%0d_cnt_total", v), cnt_total, vecs[v].e_tot);
      check($sformatf("v%0d_cnt_miss", v), cnt_miss, vecs[v].e_mcnt);
    end

    // Four valid ways, branch only in way2: way2 must be the saved record.
    do_reset();
    clear_ways();
    set_way(0, 32'h100, 32'h104, BrNone, 1'b0, 1'b1);
    set_way(1, 32'h104, 32'h108, BrNone, 1'b0, 1'b1);
    set_way(2, 32'h108, 32'h800, BrCond, 1'b1, 1'b1);
    way_info[2].bp_info.Predict_Target = 32'hABC;
    set_way(3, 32'h10C, 32'h110, BrNone, 1'b0, 1'b1);
    next_cycle();
    clear_ways();
    set_way(0, 32'h800, 32'h804, BrNone, 1'b0, 1'b1);
    @(negedge clk);
    check("sel_bp_fail", 32'(bp_fail), 32'd0);
    next_cycle();
    clear_ways();
    @(negedge clk);
    check("sel_upd_tgt", upd_data.Update_Target, 32'h800);
    check("sel_upd_loc", 32'(upd_data.Update_Location), 32'd0);
    check("sel_pred_tgt", upd_data.Predict_Target, 32'hABC);

    // No branch in the group: the highest valid way is saved.
    do_reset();
    clear_ways();
    set_way(1, 32'h200, 32'h204, BrNone, 1'b0, 1'b1);
    set_way(3, 32'h20C, 32'h210, BrNone, 1'b0, 1'b1);
    next_cycle();
    clear_ways();
    set_way(0, 32'h210, 32'h214, BrNone, 1'b0, 1'b1);
    @(negedge clk);
    check("hi_bp_fail", 32'(bp_fail), 32'd0);
    next_cycle();
    clear_ways();
    @(negedge clk);
    check("hi_upd_pc", upd_data.Update_PC, 32'h208);

    // Five pushes into a depth-4 queue with no consumer, then drain in order.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clear_ways();
      set_way(0, 32'h1000 + 32'(16 * k), 32'h1000 + 32'(16 * (k + 1)), BrCond, 1'b1, 1'b1);
      next_cycle();
    end
    clear_ways();
    @(negedge clk);
    check("fifo_cnt_drop", cnt_drop, 32'd1);
    check("fifo_full_valid", 32'(upd_valid), 32'd1);
    next_cycle();
    upd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("fifo_pop%0d_valid", k), 32'(upd_valid), 32'd1);
      check($sformatf("fifo_pop%0d_pc", k), upd_data.Update_PC, 32'h1000 + 32'(16 * k));
      next_cycle();
    end
    @(negedge clk);
    check("fifo_empty", 32'(upd_valid), 32'd0);

    // Stall with a mismatching group: no flush, no push, state held.
    do_reset();
    clear_ways();
    set_way(0, 32'h1000, 32'h2000, BrCond, 1'b1, 1'b1);
    next_cycle();
    stall = 1'b1;
    clear_ways();
    set_way(0, 32'h1008, 32'h100C, BrNone, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_bp_fail", c), 32'(bp_fail), 32'd0);
      next_cycle();
    end
    stall = 1'b0;
    clear_ways();
    @(negedge clk);
    check("stall_no_push", 32'(upd_valid), 32'd0);
    next_cycle();
    set_way(0, 32'h2000, 32'h2004, BrNone, 1'b0, 1'b1);
    @(negedge clk);
    check("stall_held_fail", 32'(bp_fail), 32'd0);
    next_cycle();
    clear_ways();
    @(negedge clk);
    check("stall_push_pc", upd_data.Update_PC, 32'h1000);

    // Counter clear priority, then asynchronous reset mid-stream.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      clear_ways();
      set_way(0, 32'h7000 + 32'(16 * k), 32'h7000 + 32'(16 * (k + 1)), BrCond, 1'b1, 1'b1);
      next_cycle();
    end
    clear_ways();
    set_way(0, 32'h7030, 32'h7040, BrCond, 1'b1, 1'b1);
    cnt_clear = 1'b1;
    @(negedge clk);
    check("clr_pre_total", cnt_total, 32'd2);
    next_cycle();
    cnt_clear = 1'b0;
    clear_ways();
    set_way(0, 32'h7040, 32'h7050, BrCond, 1'b1, 1'b1);
    @(negedge clk);
    check("clr_total", cnt_total, 32'd0);
    next_cycle();
    clear_ways();
    @(negedge clk);
    check("clr_post_total", cnt_total, 32'd1);
    check("mid_pre_valid", 32'(upd_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_upd_valid", 32'(upd_valid), 32'd0);
    check("mid_cnt_total", cnt_total, 32'd0);
    check("mid_cnt_miss", cnt_miss, 32'd0);
    check("mid_cnt_drop", cnt_drop, 32'd0);
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("mid_post_valid", 32'(upd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
